fifo_uart_tx: RTL and testbench

Read-side consumer of the byte FIFO. It pops one byte at a time from the FIFO read port and serialises it on a UART line as 8N1 (one start bit, eight data bits LSB first, one stop bit) at a fixed baud rate. It sits between the FIFO's `rclk` domain and the Basys3 USB-UART TX pin, and drains the FIFO continuously while `empty` is low.

---
 rtl/fifo_uart_tx_pkg.sv | 8 +
 rtl/fifo_uart_tx_bit_timer.sv | 27 ++
 rtl/fifo_uart_tx.sv | 100 ++++++++++
 tb/tb_fifo_uart_tx.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and widths for the FIFO-draining UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    localparam int DATA_W = 8;

endpackage

// File: rtl/fifo_uart_tx_bit_timer.sv
// Per-bit cycle counter: counts 0..BIT_DIV-1, restarting on clr or wrap.
module bit_timer #(
    parameter int unsigned BIT_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic bit_end
);

    localparam int unsigned CW = $clog2(BIT_DIV);

    logic [CW-1:0] cnt;

    assign bit_end = (cnt == CW'(BIT_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || bit_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a first-word-fall-through FIFO and sends each as an 8N1 UART frame.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              empty,
    input  logic [DATA_W-1:0] rdata,
    output logic              re,
    output logic              tx,
    output logic              busy,
    output logic              tx_done
);

    localparam int BIT_DIV = CLK_FREQ / BAUD;

    if (BIT_DIV < 2) begin : g_bad_div
        $error("fifo_uart_tx: CLK_FREQ/BAUD must be at least 2");
    end

    tx_state_t         state, state_d;
    logic [DATA_W-1:0] shift, shift_d;
    logic [2:0]        idx, idx_d;
    logic              tx_q, tx_d;
    logic              clr, bit_end;

    bit_timer #(.BIT_DIV(BIT_DIV)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .bit_end (bit_end)
    );

    // re is gated by rst so no byte is popped (and lost) while held in reset.
    always_comb begin
        state_d = state;
        shift_d = shift;
        idx_d   = idx;
        re      = 1'b0;
        tx_done = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !rst) begin
                    re      = 1'b1;
                    shift_d = rdata;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift >> 1;
                    idx_d   = idx + 3'd1;
                    if (idx == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    tx_done = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level is computed from the next state so tx changes on the same edge as state.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    assign clr  = (state_d != state);
    assign tx   = tx_q;
    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            shift <= '0;
            idx   <= '0;
            tx_q  <= 1'b1;
        end else begin
            state <= state_d;
            shift <= shift_d;
            idx   <= idx_d;
            tx_q  <= tx_d;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed and randomized checks of fifo_uart_tx against a FIFO/frame-timing model.
module tb_fifo_uart_tx;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int BD       = CLK_FREQ / BAUD;
    localparam int FRAME    = 10 * BD;
    localparam int HMAX     = 8192;

    logic       clk = 1'b0;
    logic       rst;
    logic       empty;
    logic [7:0] rdata;
    logic       re, tx, busy, tx_done;

    fifo_uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk     (clk),
        .rst     (rst),
        .empty   (empty),
        .rdata   (rdata),
        .re      (re),
        .tx      (tx),
        .busy    (busy),
        .tx_done (tx_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic tx_h[HMAX];
    logic re_h[HMAX];
    logic done_h[HMAX];
    logic busy_h[HMAX];
    int   cyc = 0;

    logic [7:0] fifo_q[$];
    int         pop_cyc[$];
    bit         scramble = 1'b0;
    int         last_pop = -1000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_inputs();
        empty = (fifo_q.size() == 0);
        if (scramble && cyc > last_pop && cyc <= last_pop + FRAME)
            rdata = 8'($urandom);
        else if (empty)
            rdata = 8'($urandom);
        else
            rdata = fifo_q[0];
    endtask

    // One clock cycle: sample outputs mid-cycle, model the FIFO pop, then update inputs.
    task automatic tick();
        if (cyc >= HMAX - 1) begin
            $display("FAIL history_budget: observed cyc=%0d limit=%0d", cyc, HMAX - 1);
            $fatal(1, "history budget exhausted");
        end
        @(negedge clk);
        tx_h[cyc]   = tx;
        re_h[cyc]   = re;
        done_h[cyc] = tx_done;
        busy_h[cyc] = busy;
        if (re === 1'b1) begin
            check("pop_when_nonempty", 32'(fifo_q.size() != 0), 32'd1);
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
            pop_cyc.push_back(cyc);
            last_pop = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
        drive_inputs();
    endtask

    task automatic run_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic wait_pops(input int target, input int budget, input string tag);
        int k = 0;
        while (pop_cyc.size() < target && k < budget) begin
            tick();
            k++;
        end
        check(tag, 32'(pop_cyc.size()), 32'(target));
    endtask

    // Frame popped in cycle n: start bit n+1..n+BD, bit k centred at n+1+BD*k+BD/2.
    task automatic check_frame(input int n, input logic [7:0] b, input string tag);
        logic [9:0] obs;
        logic [9:0] expw;
        int dn = 0;
        int bz = 0;
        int rc = 0;
        expw = {1'b1, b, 1'b0};
        for (int k = 0; k < 10; k++) obs[k] = tx_h[n + 1 + BD * k + BD / 2];
        check({tag, "_bits"}, 32'(obs), 32'(expw));
        for (int i = n + 1; i <= n + FRAME; i++) begin
            if (done_h[i] === 1'b1) dn++;
            if (busy_h[i] === 1'b1) bz++;
            if (re_h[i] !== 1'b0) rc++;
        end
        check({tag, "_done_count"}, 32'(dn), 32'd1);
        check({tag, "_done_last"}, 32'(done_h[n + FRAME]), 32'd1);
        check({tag, "_busy_len"}, 32'(bz), 32'(FRAME));
        check({tag, "_busy_pre"}, 32'(busy_h[n]), 32'd0);
        check({tag, "_busy_post"}, 32'(busy_h[n + FRAME + 1]), 32'd0);
        check({tag, "_no_repop"}, 32'(rc), 32'd0);
    endtask

    // Stop level between frame popped at n and the next popped at m.
    task automatic check_stop(input int n, input int m, input string tag);
        int ones = 0;
        for (int i = n + FRAME - BD + 1; i <= m; i++)
            if (tx_h[i] === 1'b1) ones++;
        check({tag, "_stop_ones"}, 32'(ones), 32'(BD + 1));
        check({tag, "_stop_span"}, 32'(m - (n + FRAME - BD)), 32'(BD + 1));
        check({tag, "_next_start"}, 32'(tx_h[m + 1]), 32'd0);
    endtask

    initial begin
        int viol;
        int base;
        int n;
        int m;
        int r;
        logic [7:0] bx, by;
        logic [7:0] rb[4];
        int pv[4];
        int expc;

        rst   = 1'b1;
        empty = 1'b1;
        rdata = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_re", 32'(re), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(tx_done), 32'd0);

        // Idle with an empty FIFO after reset release.
        rst = 1'b0;
        drive_inputs();
        repeat (50) tick();
        viol = 0;
        for (int i = 0; i < 50; i++)
            if (tx_h[i] !== 1'b1 || re_h[i] !== 1'b0 || busy_h[i] !== 1'b0 || done_h[i] !== 1'b0)
                viol++;
        check("idle_empty_viol", 32'(viol), 32'd0);

        // Single byte 0xA5.
        fifo_q.push_back(8'hA5);
        drive_inputs();
        wait_pops(1, 20, "a5_pop");
        n = pop_cyc[0];
        check("a5_pop_immediate", 32'(n), 32'(cyc - 1));
        run_until(n + FRAME + 3);
        check_frame(n, 8'hA5, "a5");

        // Three queued bytes back to back.
        base = pop_cyc.size();
        fifo_q.push_back(8'h00);
        fifo_q.push_back(8'hFF);
        fifo_q.push_back(8'h55);
        drive_inputs();
        wait_pops(base + 3, 400, "three_pops");
        run_until(pop_cyc[base + 2] + FRAME + 3);
        check("three_gap01", 32'(pop_cyc[base + 1] - pop_cyc[base]), 32'(FRAME + 1));
        check("three_gap12", 32'(pop_cyc[base + 2] - pop_cyc[base + 1]), 32'(FRAME + 1));
        check_frame(pop_cyc[base], 8'h00, "b00");
        check_frame(pop_cyc[base + 1], 8'hFF, "bff");
        check_frame(pop_cyc[base + 2], 8'h55, "b55");
        check_stop(pop_cyc[base], pop_cyc[base + 1], "b00_bff");

        // rdata churns mid-frame while empty stays low.
        base = pop_cyc.size();
        bx = 8'($urandom);
        by = 8'($urandom);
        scramble = 1'b1;
        fifo_q.push_back(bx);
        fifo_q.push_back(by);
        drive_inputs();
        wait_pops(base + 2, 300, "scr_pops");
        scramble = 1'b0;
        run_until(pop_cyc[base + 1] + FRAME + 3);
        check("scr_gap", 32'(pop_cyc[base + 1] - pop_cyc[base]), 32'(FRAME + 1));
        check_frame(pop_cyc[base], bx, "scr_x");
        check_frame(pop_cyc[base + 1], by, "scr_y");

        // Random bytes pushed at random times; pop cycle = max(arrival, previous pop + FRAME + 1).
        base = pop_cyc.size();
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 150)) tick();
            rb[i] = 8'($urandom);
            fifo_q.push_back(rb[i]);
            pv[i] = cyc;
            drive_inputs();
        end
        wait_pops(base + 4, 600, "rnd_pops");
        run_until(pop_cyc[base + 3] + FRAME + 3);
        expc = pop_cyc[base - 1] + FRAME + 1;
        for (int i = 0; i < 4; i++) begin
            expc = (pv[i] > expc) ? pv[i] : expc;
            check($sformatf("rnd_pop_cyc%0d", i), 32'(pop_cyc[base + i]), 32'(expc));
            check_frame(pop_cyc[base + i], rb[i], $sformatf("rnd%0d", i));
            expc = expc + FRAME + 1;
        end

        // Reset 37 cycles into a frame of 0x3C; the popped byte is lost.
        base = pop_cyc.size();
        fifo_q.push_back(8'h3C);
        fifo_q.push_back(8'h5A);
        drive_inputs();
        wait_pops(base + 1, 20, "rst_first_pop");
        n = pop_cyc[base];
        run_until(n + 37);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_tx", 32'(tx), 32'd1);
        check("rst_async_busy", 32'(busy), 32'd0);
        check("rst_async_re", 32'(re), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        r = cyc;
        wait_pops(base + 2, 5, "rst_repop");
        check("rst_repop_cycle", 32'(pop_cyc[base + 1]), 32'(r));
        run_until(pop_cyc[base + 1] + FRAME + 3);
        check_frame(pop_cyc[base + 1], 8'h5A, "rst_5a");

        // FIFO becomes non-empty in the tx_done cycle.
        base = pop_cyc.size();
        bx = 8'($urandom);
        by = 8'($urandom);
        fifo_q.push_back(bx);
        drive_inputs();
        wait_pops(base + 1, 20, "late_first_pop");
        n = pop_cyc[base];
        run_until(n + FRAME);
        fifo_q.push_back(by);
        drive_inputs();
        wait_pops(base + 2, 20, "late_second_pop");
        m = pop_cyc[base + 1];
        check("late_pop_cycle", 32'(m), 32'(n + FRAME + 1));
        run_until(m + FRAME + 3);
        check_stop(n, m, "late");
        check_frame(n, bx, "late_x");
        check_frame(m, by, "late_y");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
